// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP output stages: slice product width,
// ceiling-log2 helper and the output-register state encoding.
package dsp_pkg;

    localparam int unsigned P_W = 48;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_sat_shift.sv
// Combinational right-shift followed by unsigned saturation to OUT_W bits.
// Shared by the narrowing stages that follow wide accumulators.
module dsp_sat_shift #(
    parameter int unsigned IN_W  = 50,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned OUT_W = 24
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

    logic [IN_W-1:0] shifted_c;

    assign shifted_c = din >> SHIFT;

    generate
        if (IN_W > OUT_W) begin : g_narrow
            // Any set bit above the output word means the value does not fit.
            always_comb begin
                sat  = |shifted_c[IN_W-1:OUT_W];
                dout = sat ? {OUT_W{1'b1}} : shifted_c[OUT_W-1:0];
            end
        end else begin : g_wide
            assign sat  = 1'b0;
            assign dout = OUT_W'(shifted_c);
        end
    endgenerate

endmodule

// File: rtl/dsp_accum_out.sv
// Frame accumulator after the DSP slice: sums N_ACC samples, shifts and
// saturates the sum, and holds it in a one-deep valid/ready output register.
module dsp_accum_out
    import dsp_pkg::*;
#(
    parameter int unsigned N_ACC = 8,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned OUT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P_W-1:0]   p_in,
    input  logic             p_valid,
    input  logic             clr,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int unsigned ACC_W = P_W + clog2(N_ACC);
    localparam int unsigned CNT_W = clog2(N_ACC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    out_state_e       state_q, state_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic             overrun_q, overrun_d;
    logic [OUT_W-1:0] res_data_c;
    logic             res_sat_c;
    logic             accept_c;
    logic             frame_end_c;

    // clr discards a sample presented in the same cycle.
    assign accept_c    = p_valid && !clr;
    assign frame_end_c = accept_c && (cnt_q == CNT_LAST);
    assign sum_c       = acc_q + ACC_W'(p_in);

    dsp_sat_shift #(
        .IN_W  (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_sat_shift (
        .din  (sum_c),
        .dout (res_data_c),
        .sat  (res_sat_c)
    );

    // Accumulator and frame counter next state.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept_c) begin
            if (frame_end_c) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_c;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output register state machine and overrun tracking.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        overrun_d  = overrun_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (frame_end_c) begin
                    out_data_d = res_data_c;
                    out_sat_d  = res_sat_c;
                    state_d    = ST_FULL;
                end
            end
            ST_FULL: begin
                if (frame_end_c) begin
                    if (out_ready) begin
                        out_data_d = res_data_c;
                        out_sat_d  = res_sat_c;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_valid = (state_q == ST_FULL);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dsp_accum_out.sv
// Directed bench for dsp_accum_out (N_ACC=4, OUT_W=24); a second instance
// with SHIFT=1 shares the stimulus for the shifted saturation case.
module tb_dsp_accum_out;

    logic        clk;
    logic        rst;
    logic [47:0] p_in;
    logic        p_valid;
    logic        clr;
    logic        out_ready;
    logic [23:0] out_data, out_data1;
    logic        out_sat, out_sat1;
    logic        out_valid, out_valid1;
    logic        overrun, overrun1;

    int checks = 0;
    int errors = 0;

    dsp_accum_out #(.N_ACC(4), .SHIFT(0), .OUT_W(24)) dut (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .clr(clr),
        .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    dsp_accum_out #(.N_ACC(4), .SHIFT(1), .OUT_W(24)) dut_s1 (
        .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .clr(clr),
        .out_data(out_data1), .out_sat(out_sat1), .out_valid(out_valid1),
        .out_ready(out_ready), .overrun(overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [47:0] p;
        logic        cl;
        logic        rdy;
        logic        e_valid;
        logic [23:0] e_data;
        logic        e_sat;
        logic        e_ovr;
        logic        chk1;
        logic [23:0] e_data1;
        logic        e_sat1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic pv, input logic [47:0] p, input logic cl, input logic rdy,
                       input logic ev, input logic [23:0] ed, input logic es, input logic eo);
        vec_t v;
        v.pv = pv; v.p = p; v.cl = cl; v.rdy = rdy;
        v.e_valid = ev; v.e_data = ed; v.e_sat = es; v.e_ovr = eo;
        v.chk1 = 1'b0; v.e_data1 = '0; v.e_sat1 = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx, input logic ev, input logic [23:0] ed,
                              input logic es, input logic eo);
        check({tag, ".out_valid"}, idx, 48'(out_valid), 48'(ev));
        check({tag, ".out_data"},  idx, 48'(out_data),  48'(ed));
        check({tag, ".out_sat"},   idx, 48'(out_sat),   48'(es));
        check({tag, ".overrun"},   idx, 48'(overrun),   48'(eo));
    endtask

    task automatic drive(input logic pv, input logic [47:0] p, input logic cl, input logic rdy);
        p_valid = pv; p_in = p; clr = cl; out_ready = rdy;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1: basic frame, one-cycle valid
        add(1, 48'd1, 0, 1, 0, 24'd0,  0, 0);
        add(1, 48'd2, 0, 1, 0, 24'd0,  0, 0);
        add(1, 48'd3, 0, 1, 0, 24'd0,  0, 0);
        add(1, 48'd4, 0, 1, 1, 24'd10, 0, 0);
        add(0, 48'd0, 0, 1, 0, 24'd10, 0, 0);
        // Test 2: saturation (SHIFT=0) and shifted non-saturating (SHIFT=1)
        add(1, 48'h400000, 0, 1, 0, 24'd10, 0, 0);
        add(1, 48'h400000, 0, 1, 0, 24'd10, 0, 0);
        add(1, 48'h400000, 0, 1, 0, 24'd10, 0, 0);
        add(1, 48'h400000, 0, 1, 1, 24'hFFFFFF, 1, 0);
        vecs[$].chk1 = 1'b1; vecs[$].e_data1 = 24'h800000; vecs[$].e_sat1 = 1'b0;
        add(0, 48'd0, 0, 1, 0, 24'hFFFFFF, 1, 0);
        // Test 3: backpressure, overrun, drain, clr clears overrun
        add(1, 48'd1, 0, 0, 0, 24'hFFFFFF, 1, 0);
        add(1, 48'd2, 0, 0, 0, 24'hFFFFFF, 1, 0);
        add(1, 48'd3, 0, 0, 0, 24'hFFFFFF, 1, 0);
        add(1, 48'd4, 0, 0, 1, 24'd10, 0, 0);
        add(1, 48'd5, 0, 0, 1, 24'd10, 0, 0);
        add(1, 48'd6, 0, 0, 1, 24'd10, 0, 0);
        add(1, 48'd7, 0, 0, 1, 24'd10, 0, 0);
        add(1, 48'd8, 0, 0, 1, 24'd10, 0, 1);
        add(0, 48'd0, 0, 1, 0, 24'd10, 0, 1);
        add(0, 48'd0, 1, 0, 0, 24'd10, 0, 0);
        // Test 4: reload on the edge where FULL and ready meet a new frame end
        add(1, 48'd1, 0, 0, 0, 24'd10, 0, 0);
        add(1, 48'd1, 0, 0, 0, 24'd10, 0, 0);
        add(1, 48'd1, 0, 0, 0, 24'd10, 0, 0);
        add(1, 48'd1, 0, 0, 1, 24'd4,  0, 0);
        add(1, 48'd2, 0, 0, 1, 24'd4,  0, 0);
        add(1, 48'd2, 0, 0, 1, 24'd4,  0, 0);
        add(1, 48'd2, 0, 0, 1, 24'd4,  0, 0);
        add(1, 48'd2, 0, 1, 1, 24'd8,  0, 0);
        add(0, 48'd0, 0, 1, 0, 24'd8,  0, 0);
        // Test 5: pending output survives clr; clr drops 5,5 and the 7; gaps
        add(1, 48'd3, 0, 0, 0, 24'd8,  0, 0);
        add(1, 48'd3, 0, 0, 0, 24'd8,  0, 0);
        add(1, 48'd3, 0, 0, 0, 24'd8,  0, 0);
        add(1, 48'd3, 0, 0, 1, 24'd12, 0, 0);
        add(1, 48'd5, 0, 0, 1, 24'd12, 0, 0);
        add(1, 48'd5, 0, 0, 1, 24'd12, 0, 0);
        add(1, 48'd7, 1, 0, 1, 24'd12, 0, 0);
        add(1, 48'd1, 0, 0, 1, 24'd12, 0, 0);
        add(0, 48'd0, 0, 1, 0, 24'd12, 0, 0);
        add(1, 48'd1, 0, 1, 0, 24'd12, 0, 0);
        add(0, 48'd0, 0, 1, 0, 24'd12, 0, 0);
        add(1, 48'd1, 0, 1, 0, 24'd12, 0, 0);
        add(0, 48'd0, 0, 1, 0, 24'd12, 0, 0);
        add(0, 48'd0, 0, 1, 0, 24'd12, 0, 0);
        add(1, 48'd1, 0, 1, 1, 24'd4,  0, 0);
        add(0, 48'd0, 0, 1, 0, 24'd4,  0, 0);

        // Reset state
        drive(0, 48'd0, 0, 0);
        rst = 1'b1;
        #12;
        check_outs("reset", 0, 0, 24'd0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #6;

        foreach (vecs[i]) begin
            drive(vecs[i].pv, vecs[i].p, vecs[i].cl, vecs[i].rdy);
            step();
            check_outs("vec", i, vecs[i].e_valid, vecs[i].e_data, vecs[i].e_sat, vecs[i].e_ovr);
            if (vecs[i].chk1) begin
                check("shift1.out_data", i, 48'(out_data1), 48'(vecs[i].e_data1));
                check("shift1.out_sat",  i, 48'(out_sat1),  48'(vecs[i].e_sat1));
                check("shift1.out_valid", i, 48'(out_valid1), 48'(1'b1));
            end
        end

        // Test 6: async reset mid-frame with a pending result
        for (int k = 0; k < 4; k++) begin
            drive(1, 48'd1, 0, 0);
            step();
        end
        check_outs("pre_rst", 100, 1, 24'd4, 0, 0);
        for (int k = 0; k < 2; k++) begin
            drive(1, 48'd2, 0, 0);
            step();
        end
        drive(0, 48'd0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 101, 0, 24'd0, 0, 0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            drive(1, 48'd2, 0, 1);
        end
        step();
        check_outs("post_rst", 102, 1, 24'd8, 0, 0);
        drive(0, 48'd0, 0, 1);
        step();
        check_outs("post_rst_drain", 103, 0, 24'd8, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
